// File: rtl/blinky_monitor.sv
// Per-lane toggle counter over a fixed window; reports header + saturating counts as a byte stream.
// Latency: lane edge counted 2 clocks after capture; HDR beat appears the cycle after window end.
// Backpressure: out_data/out_valid hold while out_ready=0; a window ending mid-report sets sticky overrun.
module blinky_monitor #(
    parameter int          LANES  = 16,
    parameter int          WINDOW = 65536,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LANES-1:0]  results,
    input  logic              en,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun
);
    localparam int WW = $clog2(WINDOW);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_LANE} state_t;

    logic [LANES-1:0] sync1_q, sync2_q, prev_q;
    logic [LANES-1:0] toggle;
    logic [7:0]       cnt_q    [LANES];
    logic [7:0]       cnt_d    [LANES];
    logic [7:0]       cnt_next [LANES];
    logic [7:0]       snap_q   [LANES];
    logic [7:0]       snap_d   [LANES];
    logic [WW-1:0]    win_q, win_d;
    logic [IW-1:0]    idx_q, idx_d;
    state_t           state_q, state_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             win_end;
    logic             hs;

    always_comb begin
        toggle  = sync2_q ^ prev_q;
        win_end = en && (win_q == WIN_LAST);
        hs      = out_valid_q && out_ready;

        // cnt_next already includes this cycle's toggle, so the snapshot sees window-end edges
        for (int i = 0; i < LANES; i++) begin
            cnt_next[i] = (toggle[i] && (cnt_q[i] != 8'hFF)) ? cnt_q[i] + 8'd1 : cnt_q[i];
            cnt_d[i]    = (en && !win_end) ? cnt_next[i] : 8'h00;
            snap_d[i]   = snap_q[i];
        end
        win_d = (en && !win_end) ? win_q + WW'(1) : '0;

        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (win_end) begin
                    for (int i = 0; i < LANES; i++) snap_d[i] = cnt_next[i];
                    state_d     = S_HDR;
                    out_valid_d = 1'b1;
                    out_data_d  = HEADER;
                end
            end
            S_HDR: begin
                if (hs) begin
                    state_d    = S_LANE;
                    idx_d      = '0;
                    out_data_d = snap_q[0];
                end
            end
            S_LANE: begin
                if (hs) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        idx_d      = idx_q + IW'(1);
                        out_data_d = snap_q[idx_d];
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (win_end && (state_q != S_IDLE)) overrun_d = 1'b1;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i]  <= 8'h00;
                snap_q[i] <= 8'h00;
            end
            win_q       <= '0;
            idx_q       <= '0;
            state_q     <= S_IDLE;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= results;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i]  <= cnt_d[i];
                snap_q[i] <= snap_d[i];
            end
            win_q       <= win_d;
            idx_q       <= idx_d;
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_blinky_monitor.sv
// Randomised bench for blinky_monitor: a window-level reference model queues expected report bytes,
// a negedge monitor pops and compares each beat the DUT presents.
module tb_blinky_monitor;
    localparam int         LANES  = 16;
    localparam int         WINDOW = 256;
    localparam logic [7:0] HEADER = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [LANES-1:0] results = '0;
    logic             en = 1'b0;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    always #5 clk = ~clk;

    blinky_monitor #(.LANES(LANES), .WINDOW(WINDOW), .HEADER(HEADER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .results   (results),
        .en        (en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the value seen at edge m is counted at edge m+2; counts kept as plain ints.
    logic [7:0]       exp_q[$];
    logic [LANES-1:0] hist[$];
    int               cnt[LANES];
    int               wpos = 0;
    int               remaining = 0;
    logic             ovr_exp = 1'b0;
    logic [LANES-1:0] m_tgl;
    bit               m_busy;

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            repeat (3) hist.push_back('0);
            for (int i = 0; i < LANES; i++) cnt[i] = 0;
            wpos      = 0;
            remaining = 0;
            ovr_exp   = 1'b0;
            exp_q.delete();
        end else begin
            hist.push_back(results);
            m_tgl = hist[0] ^ hist[1];
            void'(hist.pop_front());
            m_busy = (remaining > 0);
            if (m_busy && out_ready) remaining--;
            if (en) begin
                for (int i = 0; i < LANES; i++) cnt[i] += int'(m_tgl[i]);
                if (wpos == WINDOW - 1) begin
                    if (m_busy) ovr_exp = 1'b1;
                    else begin
                        exp_q.push_back(HEADER);
                        for (int i = 0; i < LANES; i++)
                            exp_q.push_back((cnt[i] > 255) ? 8'hFF : 8'(cnt[i]));
                        remaining = LANES + 1;
                    end
                    for (int i = 0; i < LANES; i++) cnt[i] = 0;
                    wpos = 0;
                end else wpos++;
            end else begin
                for (int i = 0; i < LANES; i++) cnt[i] = 0;
                wpos = 0;
            end
        end
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) prev_stall = 1'b0;
        else begin
            check("valid", 32'(out_valid), 32'(remaining > 0));
            check("busy", 32'(busy), 32'(remaining > 0));
            check("overrun", 32'(overrun), 32'(ovr_exp));
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat: got unexpected byte %0h, expected no beat at %0t", out_data, $time);
                end else begin
                    check("beat", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: hold results, 1: sparse random flips, 2: lane0 every cycle, lane1 every other cycle
    // rmode 0: ready low, 1: ready high, 2: ready random
    task automatic run(input int n, input int mode, input int rmode);
        for (int k = 0; k < n; k++) begin
            logic [LANES-1:0] m;
            m = LANES'($urandom & $urandom & $urandom & $urandom);
            if (mode == 0) m = '0;
            if (mode == 2) begin
                m[0] = 1'b1;
                m[1] = k[0];
            end
            results   = results ^ m;
            out_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(1)) : 1'b0;
            step();
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        repeat (5) begin
            results = LANES'($urandom);
            step();
        end
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);

        rst_n   = 1'b1;
        results = LANES'($urandom);
        en      = 1'b1;
        run(2 * WINDOW, 0, 1);
        run(4 * WINDOW, 1, 2);
        run(2 * WINDOW, 2, 1);

        run(2 * WINDOW + 40, 1, 0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        run(2 * WINDOW, 1, 1);

        run(WINDOW / 3, 1, 1);
        en = 1'b0;
        run(50, 1, 1);
        en = 1'b1;
        run(2 * WINDOW, 1, 2);

        guard = 0;
        while (remaining != LANES + 1 - 6 && guard < 3 * WINDOW) begin
            run(1, 1, 1);
            guard++;
        end
        if (remaining != LANES + 1 - 6) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat7_wait: no report reached beat 7 within %0d cycles", guard);
        end else begin
            rst_n = 1'b0;
            #1;
            check("rst_mid_valid", 32'(out_valid), 32'd0);
            check("rst_mid_busy", 32'(busy), 32'd0);
            check("rst_mid_overrun", 32'(overrun), 32'd0);
        end
        step();
        step();
        rst_n = 1'b1;
        run(2 * WINDOW, 1, 1);

        en = 1'b0;
        run(40, 0, 1);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/blinky_monitor.md
# blinky_monitor

Downstream observer for the multi-lane counter test design. It consumes that design's per-lane `results` bits (the counter MSBs driven onto `io_out`). It counts toggles per lane over a fixed measurement window. At each window end it emits a framed byte report over a valid/ready stream: one header byte, then one saturating 8-bit count per lane. It sits between the design-under-test outputs and the fabric-emulation capture logic, so blink rates can be checked without a waveform dump.

## Interface
- `LANES`, 16, number of observed result lanes (1..32)
- `WINDOW`, 65536, measurement window length in clock cycles (≥ LANES+2)
- `HEADER`, 8'hA5, first byte of every report
- `clk`  in  1  single clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `results`  in  LANES  lane bits from the test design; asynchronous to `clk`, treated as untrusted
- `en`  in  1  measurement enable
- `out_data`  out  8  report byte
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts the byte when high together with `out_valid`
- `busy`  out  1  report in progress (FSM not IDLE)
- `overrun`  out  1  sticky: a window ended while a report was still in progress

## Operation
- **Input stage:** 2-flop synchronizer per lane, then a `prev` register. `toggle[i] = sync2[i] ^ prev[i]`. All three register sets reset to 0.
- **Toggle counters:** one 8-bit counter per lane. Increments on `toggle[i]` while `en`=1. Saturates at 8'hFF; never wraps.
- **Window counter:** counts 0..WINDOW-1 while `en`=1. Window end is the cycle with `en`=1 and count = WINDOW-1. On that cycle the count returns to 0.
- **`en`=0:** window counter and all toggle counters are cleared to 0 and held. The input synchronizers keep running. The report FSM is unaffected and finishes any report in flight.
- **Window end, FSM in IDLE:**
  - Snapshot all lane counts into report registers. The snapshot includes any toggle seen on the window-end cycle.
  - Clear the toggle counters.
  - FSM → HDR.
- **Window end, FSM not IDLE:**
  - Set `overrun`=1; it stays set until `rst_n`.
  - The new snapshot is dropped; the report in flight is untouched.
  - Toggle counters are still cleared.
- **Report FSM states:**
  - IDLE: `out_valid`=0.
  - HDR: `out_valid`=1, `out_data`=HEADER. On handshake → LANE with idx=0.
  - LANE: `out_valid`=1, `out_data`=snap[idx]. On handshake: if idx=LANES-1 → IDLE, else idx+1.
- **Stream rules:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold stable. `out_valid` never drops without a handshake, except on reset.
- **Outputs:** `busy` = (state ≠ IDLE), registered with the state.

## Timing
- **Reset values:** `out_data`=0, `out_valid`=0, `busy`=0, `overrun`=0. All counters, snapshot registers, synchronizers, idx = 0; state = IDLE.
- **Input latency:** a `results` edge captured by `sync1` at clock edge k increments the lane counter at edge k+2. It is counted in the window containing edge k+2.
- **Report start:** HDR state, `out_valid`=1 and `busy`=1, is visible in the cycle after the window-end edge.
- **Report length:** LANES+1 beats. With `out_ready` tied high the report takes exactly LANES+1 cycles, so no overrun occurs for WINDOW ≥ LANES+2.
- **First window:** window 0 spans the first WINDOW cycles with `en`=1 after reset release.
- **Reset mid-report:** `rst_n` low clears `out_valid` and `busy` immediately (asynchronously). No partial report resumes after reset.
- **Minimum resolvable toggle spacing:** 1 cycle. A lane toggling every cycle gives WINDOW counts, saturated at 255.

## Test plan
- **Reset:** hold `rst_n`=0, drive `results` random → all outputs 0. Release → `out_valid` stays 0 until the first window end.
- **Quiet lanes:** WINDOW=32, `en`=1, `results` constant, `out_ready`=1 → at cycle 33 the stream carries A5 followed by 16 × 8'h00, exactly one beat per cycle, then `busy`=0.
- **Single-lane count:** WINDOW=64. Toggle lane 3 exactly 5 times in cycles 10..30 → report byte 4 (lane 3) = 8'h05, all other lane bytes 8'h00.
- **Saturation:** WINDOW=1024, lane 0 toggling every cycle → lane 0 byte = 8'hFF.
- **Backpressure and overrun:** WINDOW=32, `out_ready`=0 for 40 cycles after HDR appears → `out_data`/`out_valid` stable throughout, `overrun`=1 after the second window end. Then release `out_ready` → the first snapshot is delivered intact; no second report follows until the next window end in IDLE.
- **Enable and reset mid-stream:** drop `en` mid-window → the next report after re-enable counts only toggles after re-enable. Assert `rst_n`=0 on beat 7 of a report → `out_valid`=0 in the same cycle, `overrun`=0.
